// File: rtl/nibble_frame_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nibble_pack_pkg
// Description : Shared constants and types for the nibble frame packer.
//               Holds the word/frame geometry, the FILL/HOLD state encoding
//               and the word-count type wide enough to represent a full frame.
// Revision    : 1.0 - initial release
// ============================================================================
package nibble_pack_pkg;

   localparam int WORD_W    = 4;
   localparam int NUM_WORDS = 256;
   localparam int SEL_W     = $clog2(NUM_WORDS);
   localparam int FRAME_W   = NUM_WORDS * WORD_W;

   // FILL collects words; HOLD presents a committed frame downstream.
   typedef enum logic [0:0] {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_t;

   // One bit wider than the index so that a full frame (NUM_WORDS) fits.
   typedef logic [SEL_W:0] count_t;

endpackage
`default_nettype wire

// File: rtl/nibble_frame_packer_if.sv
`default_nettype none
// ============================================================================
// Module      : nibble_frame_packer_if
// Description : Word-input and frame-output handshakes of the packer.
//   in_valid / in_ready / in_data : 4-bit word stream into the packer
//   flush                         : commit the current partial frame
//   out_valid / out_ready         : frame handshake towards consumers
//   out_data / out_count          : frame bits and number of valid words
//   wr_ptr                        : slot the next accepted word goes to
//   Modport slave is the packer side, master is the source/sink side.
// Revision    : 1.0 - initial release
// ============================================================================
interface nibble_frame_packer_if;
   import nibble_pack_pkg::*;

   logic               in_valid;
   logic               in_ready;
   logic [WORD_W-1:0]  in_data;
   logic               flush;
   logic               out_valid;
   logic               out_ready;
   logic [FRAME_W-1:0] out_data;
   count_t             out_count;
   logic [SEL_W-1:0]   wr_ptr;

   modport slave (
      input  in_valid, in_data, flush, out_ready,
      output in_ready, out_valid, out_data, out_count, wr_ptr
   );

   modport master (
      output in_valid, in_data, flush, out_ready,
      input  in_ready, out_valid, out_data, out_count, wr_ptr
   );

endinterface
`default_nettype wire

// File: rtl/nibble_frame_packer_demux_dec256.sv
`default_nettype none
// ============================================================================
// Module      : demux_dec256
// Description : SEL_W-to-NUM_WORDS one-hot write-enable decoder, gated by en.
//   sel : slot index being written
//   en  : a word is accepted this cycle
//   we  : one-hot slice write enables (all zero when en is low)
// Revision    : 1.0 - initial release
// ============================================================================
module demux_dec256
   import nibble_pack_pkg::*;
(
   input  logic [SEL_W-1:0]     sel,
   input  logic                 en,
   output logic [NUM_WORDS-1:0] we
);

   always_comb begin
      we      = '0;
      we[sel] = en;
   end

endmodule
`default_nettype wire

// File: rtl/nibble_frame_packer.sv
`default_nettype none
// ============================================================================
// Module      : nibble_frame_packer
// Description : Packs a stream of 4-bit words into a 1024-bit frame, word k at
//               bits [4k+3:4k], and hands the full or flushed frame downstream.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : word input / frame output handshakes (slave modport)
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_frame_packer
   import nibble_pack_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   nibble_frame_packer_if.slave bus
);

   state_t             state_q, state_d;
   logic [SEL_W-1:0]   wr_ptr_q, wr_ptr_d;
   count_t             count_q, count_d;
   logic [FRAME_W-1:0] frame_q, frame_d;

   logic               accept;
   logic               release_frame;
   count_t             words_held;
   logic [NUM_WORDS-1:0] slice_we;

   // Handshake outputs depend on state only; no bypass from HOLD to FILL.
   assign accept        = (state_q == FILL) && bus.in_valid;
   assign release_frame = (state_q == HOLD) && bus.out_ready;
   // Includes a word accepted in the same cycle as a flush.
   assign words_held    = count_t'(wr_ptr_q) + count_t'(accept);

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      case (state_q)
         FILL: begin
            if (accept) begin
               // Wraps to 0 naturally on the last slot.
               wr_ptr_d = wr_ptr_q + SEL_W'(1);
            end
            if (accept && (wr_ptr_q == SEL_W'(NUM_WORDS - 1))) begin
               state_d = HOLD;
               count_d = count_t'(NUM_WORDS);
            end else if (bus.flush && (words_held != '0)) begin
               state_d = HOLD;
               count_d = words_held;
            end
         end
         HOLD: begin
            if (bus.out_ready) begin
               state_d  = FILL;
               wr_ptr_d = '0;
               count_d  = '0;
            end
         end
         default: begin
            state_d = FILL;
         end
      endcase
   end

   demux_dec256 u_dec (
      .sel (wr_ptr_q),
      .en  (accept),
      .we  (slice_we)
   );

   // Each slice loads on its own enable; all slices clear when the frame is
   // released so that a later partial frame reads zero in unwritten slots.
   generate
      for (genvar k = 0; k < NUM_WORDS; k++) begin : g_slice
         assign frame_d[k*WORD_W +: WORD_W] =
            release_frame ? '0 :
            slice_we[k]   ? bus.in_data :
                            frame_q[k*WORD_W +: WORD_W];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= FILL;
         wr_ptr_q <= '0;
         count_q  <= '0;
         frame_q  <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         frame_q  <= frame_d;
      end
   end

   assign bus.in_ready  = (state_q == FILL);
   assign bus.out_valid = (state_q == HOLD);
   assign bus.out_data  = frame_q;
   assign bus.out_count = count_q;
   assign bus.wr_ptr    = wr_ptr_q;

endmodule
`default_nettype wire

// File: tb/tb_nibble_frame_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_nibble_frame_packer
// Description : Self-checking bench for nibble_frame_packer. A queue-based
//               reference model tracks the words of the frame being filled
//               and the frame being held, directed scenarios cover the
//               boundary cases and a random phase mixes all inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_frame_packer;
   import nibble_pack_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   nibble_frame_packer_if bus ();

   nibble_frame_packer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   logic [WORD_W-1:0]  cur[$];
   logic               holding;
   logic [FRAME_W-1:0] held_frame;
   int                 held_count;

   task automatic chk(input string tag, input logic [FRAME_W-1:0] got,
                      input logic [FRAME_W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [FRAME_W-1:0] cur_frame();
      logic [FRAME_W-1:0] f;
      f = '0;
      foreach (cur[i]) f[i*WORD_W +: WORD_W] = cur[i];
      return f;
   endfunction

   task automatic model_reset();
      cur.delete();
      holding    = 1'b0;
      held_frame = '0;
      held_count = 0;
   endtask

   task automatic model_step(input logic v, input logic [3:0] d,
                             input logic f, input logic r);
      if (!holding) begin
         if (v) cur.push_back(d);
         if (cur.size() == NUM_WORDS || (f && cur.size() > 0)) begin
            holding    = 1'b1;
            held_frame = cur_frame();
            held_count = cur.size();
            cur.delete();
         end
      end else if (r) begin
         holding = 1'b0;
      end
   endtask

   task automatic compare_outputs();
      chk("in_ready",  bus.in_ready,  !holding);
      chk("out_valid", bus.out_valid, holding);
      if (holding) begin
         chk("hold_data",  bus.out_data,  held_frame);
         chk("hold_count", bus.out_count, held_count);
         if (held_count == NUM_WORDS) chk("hold_wr_ptr", bus.wr_ptr, 0);
      end else begin
         chk("fill_data",   bus.out_data,  cur_frame());
         chk("fill_count",  bus.out_count, 0);
         chk("fill_wr_ptr", bus.wr_ptr,    cur.size());
      end
   endtask

   // Called at a falling edge: drive inputs, advance the model past the next
   // rising edge, then check the DUT at the following falling edge.
   task automatic cycle(input logic v, input logic [3:0] d,
                        input logic f, input logic r);
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.flush     = f;
      bus.out_ready = r;
      model_step(v, d, f, r);
      @(negedge clk);
      compare_outputs();
   endtask

   initial begin
      logic [FRAME_W-1:0] od;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;
      model_reset();

      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", bus.in_ready, 1);
      compare_outputs();

      // Full frame with in_data = k mod 16
      for (int k = 0; k < NUM_WORDS; k++) cycle(1'b1, 4'(k), 1'b0, 1'b0);
      od = bus.out_data;
      chk("full_valid", bus.out_valid, 1);
      chk("full_lo",    od[7:0], 8'h10);
      chk("full_hi",    od[FRAME_W-1 -: 8], 8'hFE);
      chk("full_count", bus.out_count, 256);
      chk("full_ptr",   bus.wr_ptr, 0);

      // Backpressure: source keeps pushing 0xF while the frame is held
      for (int k = 0; k < 10; k++) cycle(1'b1, 4'hF, 1'b0, 1'b0);
      chk("bp_stable", bus.out_data, od);
      cycle(1'b1, 4'hF, 1'b0, 1'b1);
      chk("bp_cleared", bus.out_data, 0);
      chk("bp_ready",   bus.in_ready, 1);
      cycle(1'b1, 4'h5, 1'b0, 1'b0);
      od = bus.out_data;
      chk("bp_first", od[3:0], 4'h5);
      cycle(1'b0, 4'h0, 1'b1, 1'b0);
      cycle(1'b0, 4'h0, 1'b0, 1'b1);

      // Partial flush
      cycle(1'b1, 4'hA, 1'b0, 1'b0);
      cycle(1'b1, 4'hB, 1'b0, 1'b0);
      cycle(1'b1, 4'hC, 1'b0, 1'b0);
      cycle(1'b0, 4'h0, 1'b1, 1'b0);
      od = bus.out_data;
      chk("part_lo",    od[11:0], 12'hCBA);
      chk("part_rest",  od >> 12, 0);
      chk("part_count", bus.out_count, 3);
      cycle(1'b0, 4'h0, 1'b1, 1'b1);

      // Flush together with an accept, then an empty flush
      cycle(1'b1, 4'h1, 1'b0, 1'b0);
      cycle(1'b1, 4'h2, 1'b1, 1'b0);
      od = bus.out_data;
      chk("fa_lo",    od[7:0], 8'h21);
      chk("fa_count", bus.out_count, 2);
      cycle(1'b0, 4'h0, 1'b0, 1'b1);
      cycle(1'b0, 4'h0, 1'b1, 1'b0);
      chk("empty_valid", bus.out_valid, 0);
      chk("empty_ptr",   bus.wr_ptr, 0);

      // Clear check: all-0xF frame, release, then a short frame
      for (int k = 0; k < NUM_WORDS; k++) cycle(1'b1, 4'hF, 1'b0, 1'b0);
      cycle(1'b0, 4'h0, 1'b0, 1'b1);
      cycle(1'b1, 4'h3, 1'b0, 1'b0);
      cycle(1'b1, 4'h3, 1'b0, 1'b0);
      cycle(1'b0, 4'h0, 1'b1, 1'b0);
      od = bus.out_data;
      chk("clr_lo",   od[7:0], 8'h33);
      chk("clr_rest", od >> 8, 0);
      cycle(1'b0, 4'h0, 1'b0, 1'b1);

      // Asynchronous reset in the middle of a frame
      for (int k = 0; k < 100; k++) cycle(1'b1, 4'($urandom), 1'b0, 1'b0);
      bus.in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_data",  bus.out_data, 0);
      chk("arst_ptr",   bus.wr_ptr, 0);
      chk("arst_valid", bus.out_valid, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      compare_outputs();
      for (int k = 0; k < NUM_WORDS; k++) cycle(1'b1, 4'($urandom), 1'b0, 1'b0);
      chk("arst_full_count", bus.out_count, 256);
      cycle(1'b0, 4'h0, 1'b0, 1'b1);

      // Random traffic
      for (int k = 0; k < 3000; k++) begin
         cycle(($urandom % 4) != 0, 4'($urandom), ($urandom % 64) == 0,
               ($urandom % 3) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
